// File: rtl/alu_reservation_station.sv
// Reservation station for ALU/branch/jump ops: buffers dispatched ops until both operands
// are known, snoops the ALU and LSB broadcast buses, and issues one ready op per cycle.
module alu_reservation_station #(
    parameter int RS_SIZE   = 16,
    parameter int ROB_TAG_W = 4,
    parameter int OP_W      = 6,
    parameter int XLEN      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 in_flush,
    input  logic                 in_valid,
    input  logic [OP_W-1:0]      in_op,
    input  logic [XLEN-1:0]      in_value1,
    input  logic [XLEN-1:0]      in_value2,
    input  logic [ROB_TAG_W-1:0] in_tag1,
    input  logic [ROB_TAG_W-1:0] in_tag2,
    input  logic [XLEN-1:0]      in_imm,
    input  logic [XLEN-1:0]      in_pc,
    input  logic [ROB_TAG_W-1:0] in_rob_tag,
    output logic                 out_full,
    input  logic [ROB_TAG_W-1:0] alu_cdb_tag,
    input  logic [XLEN-1:0]      alu_cdb_val,
    input  logic [ROB_TAG_W-1:0] lsb_cdb_tag,
    input  logic [XLEN-1:0]      lsb_cdb_val,
    output logic [OP_W-1:0]      out_op,
    output logic [XLEN-1:0]      out_value1,
    output logic [XLEN-1:0]      out_value2,
    output logic [XLEN-1:0]      out_imm,
    output logic [XLEN-1:0]      out_pc,
    output logic [ROB_TAG_W-1:0] out_rob_tag
);
    localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;
    localparam logic [OP_W-1:0] OP_NOP = '0;

    logic [RS_SIZE-1:0]                valid_q, valid_d;
    logic [RS_SIZE-1:0][OP_W-1:0]      op_q, op_d;
    logic [RS_SIZE-1:0][XLEN-1:0]      val1_q, val1_d;
    logic [RS_SIZE-1:0][ROB_TAG_W-1:0] tag1_q, tag1_d;
    logic [RS_SIZE-1:0][XLEN-1:0]      val2_q, val2_d;
    logic [RS_SIZE-1:0][ROB_TAG_W-1:0] tag2_q, tag2_d;
    logic [RS_SIZE-1:0][XLEN-1:0]      imm_q, imm_d;
    logic [RS_SIZE-1:0][XLEN-1:0]      pc_q, pc_d;
    logic [RS_SIZE-1:0][ROB_TAG_W-1:0] rob_tag_q, rob_tag_d;

    logic [OP_W-1:0]      out_op_q, out_op_d;
    logic [XLEN-1:0]      out_value1_q, out_value1_d;
    logic [XLEN-1:0]      out_value2_q, out_value2_d;
    logic [XLEN-1:0]      out_imm_q, out_imm_d;
    logic [XLEN-1:0]      out_pc_q, out_pc_d;
    logic [ROB_TAG_W-1:0] out_rob_tag_q, out_rob_tag_d;

    logic [RS_SIZE-1:0] ready;
    logic               issue_any, free_any;
    logic [IDX_W-1:0]   issue_idx, free_idx;

    // Resolve one source against both buses; ALU wins if both carry the same tag.
    function automatic logic [ROB_TAG_W+XLEN-1:0] snoop(
        input logic [ROB_TAG_W-1:0] tag,
        input logic [XLEN-1:0]      val,
        input logic [ROB_TAG_W-1:0] a_tag,
        input logic [XLEN-1:0]      a_val,
        input logic [ROB_TAG_W-1:0] l_tag,
        input logic [XLEN-1:0]      l_val
    );
        if (tag != '0 && tag == a_tag) return {{ROB_TAG_W{1'b0}}, a_val};
        if (tag != '0 && tag == l_tag) return {{ROB_TAG_W{1'b0}}, l_val};
        return {tag, val};
    endfunction

    always_comb begin : select
        ready     = '0;
        issue_any = 1'b0;
        issue_idx = '0;
        free_any  = 1'b0;
        free_idx  = '0;
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            ready[i] = valid_q[i] && (tag1_q[i] == '0) && (tag2_q[i] == '0);
            if (ready[i] && !issue_any) begin
                issue_any = 1'b1;
                issue_idx = IDX_W'(i);
            end
            if (!valid_q[i] && !free_any) begin
                free_any = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin : next_state
        valid_d       = valid_q;
        op_d          = op_q;
        val1_d        = val1_q;
        tag1_d        = tag1_q;
        val2_d        = val2_q;
        tag2_d        = tag2_q;
        imm_d         = imm_q;
        pc_d          = pc_q;
        rob_tag_d     = rob_tag_q;
        out_op_d      = out_op_q;
        out_value1_d  = out_value1_q;
        out_value2_d  = out_value2_q;
        out_imm_d     = out_imm_q;
        out_pc_d      = out_pc_q;
        out_rob_tag_d = out_rob_tag_q;

        if (rdy) begin
            out_op_d      = OP_NOP;
            out_value1_d  = '0;
            out_value2_d  = '0;
            out_imm_d     = '0;
            out_pc_d      = '0;
            out_rob_tag_d = '0;
            if (in_flush) begin
                valid_d = '0;
            end else begin
                for (int unsigned i = 0; i < RS_SIZE; i++) begin
                    if (valid_q[i]) begin
                        {tag1_d[i], val1_d[i]} = snoop(tag1_q[i], val1_q[i], alu_cdb_tag,
                                                       alu_cdb_val, lsb_cdb_tag, lsb_cdb_val);
                        {tag2_d[i], val2_d[i]} = snoop(tag2_q[i], val2_q[i], alu_cdb_tag,
                                                       alu_cdb_val, lsb_cdb_tag, lsb_cdb_val);
                    end
                end

                // Ready entries have no pending tags, so their registered values are final.
                if (issue_any) begin
                    valid_d[issue_idx] = 1'b0;
                    out_op_d           = op_q[issue_idx];
                    out_value1_d       = val1_q[issue_idx];
                    out_value2_d       = val2_q[issue_idx];
                    out_imm_d          = imm_q[issue_idx];
                    out_pc_d           = pc_q[issue_idx];
                    out_rob_tag_d      = rob_tag_q[issue_idx];
                end

                // free_idx comes from registered valid bits, so a slot freed by this
                // cycle's issue is not picked; a dispatch while full is dropped.
                if (in_valid && free_any) begin
                    valid_d[free_idx]   = 1'b1;
                    op_d[free_idx]      = in_op;
                    imm_d[free_idx]     = in_imm;
                    pc_d[free_idx]      = in_pc;
                    rob_tag_d[free_idx] = in_rob_tag;
                    {tag1_d[free_idx], val1_d[free_idx]} = snoop(in_tag1, in_value1, alu_cdb_tag,
                                                                 alu_cdb_val, lsb_cdb_tag, lsb_cdb_val);
                    {tag2_d[free_idx], val2_d[free_idx]} = snoop(in_tag2, in_value2, alu_cdb_tag,
                                                                 alu_cdb_val, lsb_cdb_tag, lsb_cdb_val);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q       <= '0;
            op_q          <= '0;
            val1_q        <= '0;
            tag1_q        <= '0;
            val2_q        <= '0;
            tag2_q        <= '0;
            imm_q         <= '0;
            pc_q          <= '0;
            rob_tag_q     <= '0;
            out_op_q      <= OP_NOP;
            out_value1_q  <= '0;
            out_value2_q  <= '0;
            out_imm_q     <= '0;
            out_pc_q      <= '0;
            out_rob_tag_q <= '0;
        end else begin
            valid_q       <= valid_d;
            op_q          <= op_d;
            val1_q        <= val1_d;
            tag1_q        <= tag1_d;
            val2_q        <= val2_d;
            tag2_q        <= tag2_d;
            imm_q         <= imm_d;
            pc_q          <= pc_d;
            rob_tag_q     <= rob_tag_d;
            out_op_q      <= out_op_d;
            out_value1_q  <= out_value1_d;
            out_value2_q  <= out_value2_d;
            out_imm_q     <= out_imm_d;
            out_pc_q      <= out_pc_d;
            out_rob_tag_q <= out_rob_tag_d;
        end
    end

    assign out_full    = &valid_q;
    assign out_op      = out_op_q;
    assign out_value1  = out_value1_q;
    assign out_value2  = out_value2_q;
    assign out_imm     = out_imm_q;
    assign out_pc      = out_pc_q;
    assign out_rob_tag = out_rob_tag_q;

endmodule
